axil_req_adapter: RTL and testbench
===================================

AXIL_REQ_ADAPTER -- requirements
Module: axil_req_adapter

Interface
REQ-001 Parameter ADDR_W, default 32: request address width.
REQ-002 Parameter DATA_W, default 32: data width; only 32 is supported.
REQ-003 clk  input  1  clock; all logic is rising-edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 s_awvalid/s_awready  in/out  1/1  AXI4-Lite write-address handshake; s_awaddr  input  ADDR_W.
REQ-006 s_wvalid/s_wready  in/out  1/1  write-data handshake; s_wdata  input  32; s_wstrb  input  4.
REQ-007 s_bvalid/s_bready  out/in  1/1  write-response handshake; s_bresp  output  2.
REQ-008 s_arvalid/s_arready  in/out  1/1  read-address handshake; s_araddr  input  ADDR_W.
REQ-009 s_rvalid/s_rready  out/in  1/1  read-data handshake; s_rdata  output  32; s_rresp  output  2.
REQ-010 req_valid, req_write  output  1  request to the downstream APB master; req_addr  output  ADDR_W; req_wdata  output  32.
REQ-011 req_ready  input  1  one-cycle completion pulse; req_rdata  input  32; req_error  input  1; both sampled only when req_ready=1.

Function
REQ-012 The block SHALL hold three one-entry buffers (AW, W, AR); each *ready output SHALL be 1 exactly when its buffer is empty, independent of FSM state.
REQ-013 A buffer SHALL fill on a valid&ready edge and SHALL clear only when its transaction completes.
REQ-014 The FSM SHALL have the states IDLE, REQ, WRESP and RRESP.
REQ-015 IDLE, write candidate: AW and W buffers both full.
REQ-016 IDLE, read candidate: AR buffer full.
REQ-017 IDLE, both candidates present: the block SHALL pick the opposite of the last issued type; after reset, write wins.
REQ-018 Write error check: a chosen write with s_wstrb != 4'hF or addr[1:0] != 0 SHALL skip REQ, go directly to WRESP with bresp=2'b10 (SLVERR), and issue no downstream request.
REQ-019 Read error check: a chosen read with addr[1:0] != 0 SHALL go directly to RRESP with rresp=2'b10 and rdata=0.
REQ-020 REQ state: req_valid=1, with req_write, req_addr and req_wdata driven from the buffers and held stable until req_ready.
REQ-021 On req_ready in REQ, the block SHALL capture req_rdata and req_error, clear the buffers used, and move to WRESP (write) or RRESP (read) on the next cycle.
REQ-022 Write response: bresp = req_error ? 2'b10 : 2'b00.
REQ-023 Read response: rresp = req_error ? 2'b10 : 2'b00, and rdata = the captured req_rdata.
REQ-024 req_ready outside REQ SHALL be ignored.
REQ-025 WRESP: s_bvalid=1 until s_bready, then IDLE. RRESP: s_rvalid=1 until s_rready, then IDLE.
REQ-026 Response outputs SHALL stay stable while valid is high and not yet accepted.
REQ-027 Latency: with an idle downstream, req_valid SHALL rise the second cycle after the edge on which the last of AW/W (or AR) handshakes completes; the response valid SHALL rise one cycle after req_ready.
REQ-028 AW and W SHALL be accepted in either order or together; a second AW SHALL stall (awready=0) until the pending write completes.
REQ-029 New address/data SHALL be accepted during WRESP/RRESP, because buffers clear at completion.
REQ-030 At most one downstream request SHALL be outstanding at any time.

Reset
REQ-031 On rst_n=0 the FSM SHALL enter IDLE and all buffers SHALL be empty.
REQ-032 While in reset, all *valid outputs and req_* outputs SHALL be 0; *ready outputs SHALL be 1 after reset release.
REQ-033 Write SHALL hold priority after reset.
REQ-034 Reset mid-operation SHALL drop req_valid and any response valid immediately (asynchronously) and discard in-flight transactions; no response is issued for them.

Structure
REQ-035 Shared package axil_apb_pkg SHALL hold the FSM state encoding and the response constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
REQ-036 Sub-module axil_hold_reg (one-entry valid/ready holding register, parameterised width) SHALL be instantiated three times, for the AW, W and AR buffers.

Verification
REQ-037 Write 0x40 data 0xDEADBEEF strb F, req_ready pulse 3 cycles after req_valid, error=0 -> one req_valid burst with req_write=1 and stable fields; bresp=00.
REQ-038 W issued 4 cycles before AW at 0x10 -> no req_valid before AW is accepted; correct req_addr and req_wdata.
REQ-039 Read 0x44, downstream returns rdata 0x12345678 with error=1 -> rdata=0x12345678, rresp=10.
REQ-040 Write strb 4'h3, then read addr 0x02 -> both return SLVERR and req_valid never asserts.
REQ-041 Write and read pending together, twice in a row -> issue order W, R, W, R.
REQ-042 rst_n low during REQ -> req_valid=0 in the same cycle; after release all *ready=1 and no stale response appears.

Source files
------------

// File: rtl/axil_apb_pkg.sv
// Shared types and constants for the AXI4-Lite to APB request path.
package axil_apb_pkg;

    localparam int unsigned WDATA_W = 32;
    localparam int unsigned STRB_W  = 4;
    localparam int unsigned RESP_W  = 2;

    localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WRESP = 2'd2,
        ST_RRESP = 2'd3
    } state_e;

    // Write-data beat as held in the W buffer.
    typedef struct packed {
        logic [WDATA_W-1:0] data;
        logic [STRB_W-1:0]  strb;
    } wbeat_t;

    localparam int unsigned WBEAT_W = $bits(wbeat_t);

    // Only word-aligned accesses reach the downstream bus.
    function automatic logic misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/axil_hold_reg.sv
// One-entry holding register: accepts a beat when empty, keeps it until cleared.
module axil_hold_reg #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         clear,
    output logic [W-1:0] data
);

    // Ready doubles as the "empty" flag; fill on handshake, empty on clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready <= 1'b1;
            data     <= '0;
        end else if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            data     <= in_data;
        end else if (clear) begin
            in_ready <= 1'b1;
        end
    end

endmodule

// File: rtl/axil_req_adapter.sv
// AXI4-Lite slave front end that serialises reads/writes into single
// downstream requests for an APB master, one outstanding at a time.
module axil_req_adapter
    import axil_apb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32   // only 32 is supported
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [ADDR_W-1:0] s_awaddr,
    input  logic              s_wvalid,
    output logic              s_wready,
    input  logic [DATA_W-1:0] s_wdata,
    input  logic [3:0]        s_wstrb,
    output logic              s_bvalid,
    input  logic              s_bready,
    output logic [1:0]        s_bresp,
    input  logic              s_arvalid,
    output logic              s_arready,
    input  logic [ADDR_W-1:0] s_araddr,
    output logic              s_rvalid,
    input  logic              s_rready,
    output logic [DATA_W-1:0] s_rdata,
    output logic [1:0]        s_rresp,
    output logic              req_valid,
    output logic              req_write,
    output logic [ADDR_W-1:0] req_addr,
    output logic [DATA_W-1:0] req_wdata,
    input  logic              req_ready,
    input  logic [DATA_W-1:0] req_rdata,
    input  logic              req_error
);

    logic [ADDR_W-1:0]  aw_q;
    logic [ADDR_W-1:0]  ar_q;
    logic [WBEAT_W-1:0] w_bits;
    wbeat_t             w_in;
    wbeat_t             w_q;
    logic               aw_clr;
    logic               w_clr;
    logic               ar_clr;

    assign w_in.data = WDATA_W'(s_wdata);
    assign w_in.strb = s_wstrb;
    assign w_q       = wbeat_t'(w_bits);

    axil_hold_reg #(.W(ADDR_W)) u_aw_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (s_awvalid),
        .in_ready (s_awready),
        .in_data  (s_awaddr),
        .clear    (aw_clr),
        .data     (aw_q)
    );

    axil_hold_reg #(.W(WBEAT_W)) u_w_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (s_wvalid),
        .in_ready (s_wready),
        .in_data  (w_in),
        .clear    (w_clr),
        .data     (w_bits)
    );

    axil_hold_reg #(.W(ADDR_W)) u_ar_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (s_arvalid),
        .in_ready (s_arready),
        .in_data  (s_araddr),
        .clear    (ar_clr),
        .data     (ar_q)
    );

    state_e            state;
    state_e            state_nxt;
    logic              last_rd;
    logic              last_rd_nxt;
    logic              req_valid_nxt;
    logic              req_write_nxt;
    logic [ADDR_W-1:0] req_addr_nxt;
    logic [DATA_W-1:0] req_wdata_nxt;
    logic              bvalid_nxt;
    logic [1:0]        bresp_nxt;
    logic              rvalid_nxt;
    logic [DATA_W-1:0] rdata_nxt;
    logic [1:0]        rresp_nxt;
    logic              wr_cand;
    logic              rd_cand;
    logic              pick_wr;

    // Next-state, buffer-clear and next-output decode; outputs hold by default.
    always_comb begin
        state_nxt     = state;
        last_rd_nxt   = last_rd;
        req_valid_nxt = req_valid;
        req_write_nxt = req_write;
        req_addr_nxt  = req_addr;
        req_wdata_nxt = req_wdata;
        bvalid_nxt    = s_bvalid;
        bresp_nxt     = s_bresp;
        rvalid_nxt    = s_rvalid;
        rdata_nxt     = s_rdata;
        rresp_nxt     = s_rresp;
        aw_clr        = 1'b0;
        w_clr         = 1'b0;
        ar_clr        = 1'b0;
        wr_cand       = !s_awready && !s_wready;
        rd_cand       = !s_arready;
        // On a tie, alternate against the last issued type.
        pick_wr       = wr_cand && (!rd_cand || last_rd);

        case (state)
            ST_IDLE: begin
                if (pick_wr) begin
                    last_rd_nxt = 1'b0;
                    if (w_q.strb != 4'hF || misaligned(aw_q[1:0])) begin
                        aw_clr     = 1'b1;
                        w_clr      = 1'b1;
                        bvalid_nxt = 1'b1;
                        bresp_nxt  = RESP_SLVERR;
                        state_nxt  = ST_WRESP;
                    end else begin
                        req_valid_nxt = 1'b1;
                        req_write_nxt = 1'b1;
                        req_addr_nxt  = aw_q;
                        req_wdata_nxt = DATA_W'(w_q.data);
                        state_nxt     = ST_REQ;
                    end
                end else if (rd_cand) begin
                    last_rd_nxt = 1'b1;
                    if (misaligned(ar_q[1:0])) begin
                        ar_clr     = 1'b1;
                        rvalid_nxt = 1'b1;
                        rresp_nxt  = RESP_SLVERR;
                        rdata_nxt  = '0;
                        state_nxt  = ST_RRESP;
                    end else begin
                        req_valid_nxt = 1'b1;
                        req_write_nxt = 1'b0;
                        req_addr_nxt  = ar_q;
                        req_wdata_nxt = '0;
                        state_nxt     = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (req_ready) begin
                    req_valid_nxt = 1'b0;
                    if (req_write) begin
                        aw_clr     = 1'b1;
                        w_clr      = 1'b1;
                        bvalid_nxt = 1'b1;
                        bresp_nxt  = req_error ? RESP_SLVERR : RESP_OKAY;
                        state_nxt  = ST_WRESP;
                    end else begin
                        ar_clr     = 1'b1;
                        rvalid_nxt = 1'b1;
                        rresp_nxt  = req_error ? RESP_SLVERR : RESP_OKAY;
                        rdata_nxt  = req_rdata;
                        state_nxt  = ST_RRESP;
                    end
                end
            end
            ST_WRESP: begin
                if (s_bready) begin
                    bvalid_nxt = 1'b0;
                    state_nxt  = ST_IDLE;
                end
            end
            ST_RRESP: begin
                if (s_rready) begin
                    rvalid_nxt = 1'b0;
                    state_nxt  = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State and registered outputs; reset drops every valid immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            last_rd   <= 1'b1;
            req_valid <= 1'b0;
            req_write <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            s_bvalid  <= 1'b0;
            s_bresp   <= RESP_OKAY;
            s_rvalid  <= 1'b0;
            s_rdata   <= '0;
            s_rresp   <= RESP_OKAY;
        end else begin
            state     <= state_nxt;
            last_rd   <= last_rd_nxt;
            req_valid <= req_valid_nxt;
            req_write <= req_write_nxt;
            req_addr  <= req_addr_nxt;
            req_wdata <= req_wdata_nxt;
            s_bvalid  <= bvalid_nxt;
            s_bresp   <= bresp_nxt;
            s_rvalid  <= rvalid_nxt;
            s_rdata   <= rdata_nxt;
            s_rresp   <= rresp_nxt;
        end
    end

endmodule

// File: tb/tb_axil_req_adapter.sv
// Directed plus randomized bench for axil_req_adapter with a transaction-level model.
module tb_axil_req_adapter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_awvalid, s_awready;
    logic [31:0] s_awaddr;
    logic        s_wvalid, s_wready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_bvalid, s_bready;
    logic [1:0]  s_bresp;
    logic        s_arvalid, s_arready;
    logic [31:0] s_araddr;
    logic        s_rvalid, s_rready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        req_valid, req_write;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready;
    logic [31:0] req_rdata;
    logic        req_error;

    always #5 clk = ~clk;

    axil_req_adapter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_awaddr  (s_awaddr),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready),
        .s_bresp   (s_bresp),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_araddr  (s_araddr),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .req_rdata (req_rdata),
        .req_error (req_error)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    // Model of arbitration history: 1 means the next tie goes to the write.
    bit          model_wr_wins = 1'b1;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected response for a downstream completion.
    function automatic logic [1:0] resp_of(input logic err);
        return err ? 2'b10 : 2'b00;
    endfunction

    task automatic send_write(input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, input int order, input int gap);
        check("awready_idle", 96'(s_awready), 96'(1));
        check("wready_idle", 96'(s_wready), 96'(1));
        s_awaddr = addr;
        s_wdata  = data;
        s_wstrb  = strb;
        if (order == 0) begin
            s_awvalid = 1'b1;
            s_wvalid  = 1'b1;
            tick();
            s_awvalid = 1'b0;
            s_wvalid  = 1'b0;
        end else if (order == 1) begin
            s_awvalid = 1'b1;
            tick();
            s_awvalid = 1'b0;
            check("aw_stall", 96'(s_awready), 96'(0));
            for (int i = 0; i < gap; i++) begin
                tick();
                check("no_req_before_w", 96'(req_valid), 96'(0));
            end
            s_wvalid = 1'b1;
            tick();
            s_wvalid = 1'b0;
        end else begin
            s_wvalid = 1'b1;
            tick();
            s_wvalid = 1'b0;
            check("w_stall", 96'(s_wready), 96'(0));
            for (int i = 0; i < gap; i++) begin
                tick();
                check("no_req_before_aw", 96'(req_valid), 96'(0));
            end
            s_awvalid = 1'b1;
            tick();
            s_awvalid = 1'b0;
        end
    endtask

    // Hold off the downstream completion for dly cycles, then pulse req_ready.
    task automatic serve(input int dly, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data, input logic [31:0] rd, input logic err);
        for (int i = 0; i < dly; i++) begin
            tick();
            check("req_hold", {req_valid, req_write, req_addr}, {1'b1, wr, addr});
            if (wr) check("req_wdata_hold", 96'(req_wdata), 96'(data));
        end
        req_ready = 1'b1;
        req_rdata = rd;
        req_error = err;
        tick();
        req_ready = 1'b0;
        req_rdata = $urandom;
        req_error = 1'($urandom);
        check("req_drop", 96'(req_valid), 96'(0));
    endtask

    task automatic accept_b(input int dly, input logic [1:0] exp);
        check("bvalid_rise", {s_bvalid, s_bresp}, {1'b1, exp});
        for (int i = 0; i < dly; i++) begin
            tick();
            check("b_hold", {s_bvalid, s_bresp}, {1'b1, exp});
        end
        s_bready = 1'b1;
        tick();
        s_bready = 1'b0;
        check("b_done", 96'(s_bvalid), 96'(0));
    endtask

    task automatic accept_r(input int dly, input logic [1:0] exp, input logic [31:0] data);
        check("rvalid_rise", {s_rvalid, s_rresp, s_rdata}, {1'b1, exp, data});
        for (int i = 0; i < dly; i++) begin
            tick();
            check("r_hold", {s_rvalid, s_rresp, s_rdata}, {1'b1, exp, data});
        end
        s_rready = 1'b1;
        tick();
        s_rready = 1'b0;
        check("r_done", 96'(s_rvalid), 96'(0));
    endtask

    task automatic run_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int order, input int gap, input int dly,
                             input logic err, input int bdly);
        bit bad;
        bad = (strb != 4'hF) || (addr[1:0] != 2'b00);
        send_write(addr, data, strb, order, gap);
        check("wr_lat_low", 96'(req_valid), 96'(0));
        tick();
        model_wr_wins = 1'b0;
        if (bad) begin
            check("wr_err_no_req", 96'(req_valid), 96'(0));
            check("wr_err_bufs_free", {s_awready, s_wready}, 96'(2'b11));
            accept_b(bdly, 2'b10);
        end else begin
            check("wr_req", {req_valid, req_write, req_addr}, {1'b1, 1'b1, addr});
            check("wr_req_wdata", 96'(req_wdata), 96'(data));
            serve(dly, 1'b1, addr, data, $urandom, err);
            check("wr_bufs_free", {s_awready, s_wready}, 96'(2'b11));
            accept_b(bdly, resp_of(err));
        end
    endtask

    task automatic run_read(input logic [31:0] addr, input int dly, input logic [31:0] rd,
                            input logic err, input int rdly);
        bit bad;
        bad = addr[1:0] != 2'b00;
        check("arready_idle", 96'(s_arready), 96'(1));
        s_araddr  = addr;
        s_arvalid = 1'b1;
        tick();
        s_arvalid = 1'b0;
        check("rd_lat_low", 96'(req_valid), 96'(0));
        tick();
        model_wr_wins = 1'b1;
        if (bad) begin
            check("rd_err_no_req", 96'(req_valid), 96'(0));
            accept_r(rdly, 2'b10, 32'h0);
        end else begin
            check("rd_req", {req_valid, req_write, req_addr}, {1'b1, 1'b0, addr});
            serve(dly, 1'b0, addr, 32'h0, rd, err);
            check("rd_buf_free", 96'(s_arready), 96'(1));
            accept_r(rdly, resp_of(err), rd);
        end
    endtask

    // Load a write and a read in the same cycle, then drain both in model order.
    task automatic run_pair(input logic [31:0] waddr, input logic [31:0] wdata, input logic [31:0] raddr);
        logic [31:0] rd;
        logic        exp_wr;
        check("pair_ready", {s_awready, s_wready, s_arready}, 96'(3'b111));
        s_awaddr  = waddr;
        s_wdata   = wdata;
        s_wstrb   = 4'hF;
        s_araddr  = raddr;
        s_awvalid = 1'b1;
        s_wvalid  = 1'b1;
        s_arvalid = 1'b1;
        tick();
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        s_arvalid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            exp_wr = (k == 0) ? model_wr_wins : !model_wr_wins;
            tick();
            check("pair_order", {req_valid, req_write}, {1'b1, exp_wr});
            check("pair_addr", 96'(req_addr), 96'(exp_wr ? waddr : raddr));
            rd = $urandom;
            serve(1, exp_wr, exp_wr ? waddr : raddr, wdata, rd, 1'b0);
            if (exp_wr) accept_b(0, 2'b00);
            else        accept_r(0, 2'b00, rd);
        end
        // Both types issued, the read last: next tie goes to the write.
        model_wr_wins = exp_wr ? 1'b0 : 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        s_awvalid = 1'b0;
        s_awaddr  = '0;
        s_wvalid  = 1'b0;
        s_wdata   = '0;
        s_wstrb   = '0;
        s_bready  = 1'b0;
        s_arvalid = 1'b0;
        s_araddr  = '0;
        s_rready  = 1'b0;
        req_ready = 1'b0;
        req_rdata = '0;
        req_error = 1'b0;
        #1;
        check("rst_valids", {s_bvalid, s_rvalid, req_valid}, 96'(0));
        check("rst_req_fields", {req_write, req_addr, req_wdata}, 96'(0));
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_ready", {s_awready, s_wready, s_arready}, 96'(3'b111));
        check("post_rst_valids", {s_bvalid, s_rvalid, req_valid}, 96'(0));

        // Basic write, completion 3 cycles after req_valid.
        run_write(32'h40, 32'hDEAD_BEEF, 4'hF, 0, 0, 3, 1'b0, 1);
        // W well ahead of AW.
        run_write(32'h10, 32'hCAFE_0010, 4'hF, 2, 3, 1, 1'b0, 0);
        // Read with downstream error.
        run_read(32'h44, 2, 32'h1234_5678, 1'b1, 1);
        // Local SLVERR paths.
        run_write(32'h20, 32'h5555_AAAA, 4'h3, 1, 1, 0, 1'b0, 1);
        run_read(32'h02, 0, 32'h0, 1'b0, 2);

        // Stray req_ready while idle has no effect.
        req_ready = 1'b1;
        req_error = 1'b1;
        tick();
        req_ready = 1'b0;
        check("stray_ready", {s_bvalid, s_rvalid, req_valid}, 96'(0));
        tick();
        check("stray_ready_2", {s_bvalid, s_rvalid, req_valid}, 96'(0));

        // Randomized single transactions.
        for (int t = 0; t < 40; t++) begin
            logic [31:0] a;
            logic [3:0]  s;
            a = $urandom;
            a[1:0] = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            s = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hF;
            if ($urandom_range(0, 1) == 1)
                run_write(a, $urandom, s, $urandom_range(0, 2), $urandom_range(0, 3),
                          $urandom_range(0, 3), 1'($urandom), $urandom_range(0, 2));
            else
                run_read(a, $urandom_range(0, 3), $urandom, 1'($urandom), $urandom_range(0, 2));
        end

        // Reset while a request is outstanding.
        send_write(32'h80, 32'h0BAD_F00D, 4'hF, 0, 0);
        tick();
        check("pre_rst_req", 96'(req_valid), 96'(1));
        #2 rst_n = 1'b0;
        #1;
        check("async_drop", {req_valid, s_bvalid, s_rvalid}, 96'(0));
        model_wr_wins = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("rst2_ready", {s_awready, s_wready, s_arready}, 96'(3'b111));
        for (int i = 0; i < 4; i++) begin
            req_ready = 1'b1;
            tick();
            req_ready = 1'b0;
            check("no_stale", {req_valid, s_bvalid, s_rvalid}, 96'(0));
        end

        // Simultaneous write and read, twice: expect W, R, W, R.
        run_pair(32'h100, 32'h1111_2222, 32'h104);
        run_pair(32'h108, 32'h3333_4444, 32'h10C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Absolute time limit so a stuck DUT still ends the run.
    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "time limit");
    end

endmodule
